// File: rtl/hamming_encode_arbiter_if.sv
// hamming_encode_arbiter_if: the byte request bus and the codeword channel.
// With HAMMING_SECDED_EN defined, CW_W defaults to 8 so the parity bit fits.
interface hamming_encode_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2,
`ifdef HAMMING_SECDED_EN
  parameter int CW_W    = 8
`else
  parameter int CW_W    = 7
`endif
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cw_valid;
  logic                 cw_ready;
  logic [CW_W-1:0]      cw_data;
  logic [SRC_W-1:0]     cw_src;
  logic                 cw_last;

  modport master (
    output req_valid, req_data, cw_ready,
    input  req_ready, cw_valid, cw_data, cw_src, cw_last
  );

  modport slave (
    input  req_valid, req_data, cw_ready,
    output req_ready, cw_valid, cw_data, cw_src, cw_last
  );
endinterface

// File: rtl/hamming_encode_arbiter.sv
// hamming_encode_arbiter: round-robin share of one Hamming(7,4) encoder.
// Define HAMMING_SECDED_EN for an 8-bit codeword with overall even parity.
module hamming_encode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic clk,
  input  logic reset_n,
  hamming_encode_arbiter_if.slave bus,
  output logic busy
);
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = 8;
`else
  localparam int CW_W = 7;
`endif

  typedef enum logic {IDLE, HIGH} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [3:0]       hi_q, hi_d;
  logic             vld_q, vld_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             last_q, last_d;

  logic             load_ok;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] scan;
  logic [7:0]       bytes [NUM_REQ];

  function automatic logic [CW_W-1:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3] ^ d[2] ^ d[0],
         d[3] ^ d[1] ^ d[0],
         d[3],
         d[2] ^ d[1] ^ d[0],
         d[2], d[1], d[0]};
`ifdef HAMMING_SECDED_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
    assign bytes[g] = bus.req_data[8*g +: 8];
  end

  assign load_ok = !vld_q || bus.cw_ready;

  // first valid requester at or after rr_q, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = SRC_W'((32'(rr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!gnt_vld && bus.req_valid[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  // next state, output slot loads and the accept strobe
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    hi_d          = hi_q;
    vld_d         = vld_q;
    cw_d          = cw_q;
    src_d         = src_q;
    last_d        = last_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld && load_ok) begin
          bus.req_ready[gnt_idx] = 1'b1;
          hi_d    = bytes[gnt_idx][7:4];
          cw_d    = encode(bytes[gnt_idx][3:0]);
          src_d   = gnt_idx;
          last_d  = 1'b0;
          vld_d   = 1'b1;
          rr_d    = (gnt_idx == SRC_W'(NUM_REQ - 1)) ?
                    '0 : gnt_idx + 1'b1;
          state_d = HIGH;
        end else if (bus.cw_ready) begin
          vld_d = 1'b0;
        end
      end
      HIGH: begin
        if (load_ok) begin
          cw_d    = encode(hi_q);
          last_d  = 1'b1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, pointer, latched nibble and the output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      hi_q    <= '0;
      vld_q   <= 1'b0;
      cw_q    <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hi_q    <= hi_d;
      vld_q   <= vld_d;
      cw_q    <= cw_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign bus.cw_valid = vld_q;
  assign bus.cw_data  = cw_q;
  assign bus.cw_src   = src_q;
  assign bus.cw_last  = last_q;
  assign busy         = (state_q != IDLE) || vld_q;
endmodule

// File: doc/hamming_encode_arbiter.md
Name: hamming_encode_arbiter

Overview:
- Shares one Hamming(7,4) encode path between NUM_REQ byte requesters.
- Round-robin arbiter grants one requester and latches its byte, which is sent as two nibbles, low first.
- Each nibble is encoded and presented on a single registered codeword output with valid/ready backpressure.
- Sits between the byte-producing front-ends and the codeword channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of the source index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept; combinational.
- cw_valid  out  1  codeword valid (registered).
- cw_ready  in  1  downstream accept.
- cw_data  out  CW_W  codeword; CW_W=7, or 8 with HAMMING_SECDED_EN.
- cw_src  out  SRC_W  index of the requester that owns cw_data.
- cw_last  out  1  1 = high nibble, the second codeword of the byte.
- busy  out  1  state != IDLE or cw_valid.

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low.
- Reset values: cw_valid=0, cw_data=0, cw_src=0, cw_last=0, rr_ptr=0, state=IDLE, byte latch=0.
- Reset mid-operation discards any latched byte and pending codeword; nothing is replayed.
- Encode rule, nibble d[3:0]:
  - p1=d3^d2^d0, p2=d3^d1^d0, p3=d2^d1^d0.
  - Codeword = {p1,p2,d3,p3,d2,d1,d0}, with p1 at bit 6.
- Output-slot load condition: load_ok = !cw_valid || cw_ready.
- FSM states: IDLE, HIGH.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1 only when load_ok; all other req_ready bits are 0.
  - On accept edge: latch the byte and grant index; load the low-nibble codeword into the output register with cw_last=0 and cw_src=grant; set cw_valid=1; rr_ptr=(grant+1) mod NUM_REQ; go to HIGH.
  - No req_valid: cw_valid clears if cw_ready, else holds.
- HIGH:
  - req_ready=0 throughout.
  - When load_ok: load the high-nibble codeword with cw_last=1 and the same cw_src; go to IDLE.
  - Otherwise hold.
- Latency and throughput:
  - Low codeword is visible the cycle after accept.
  - High codeword follows one cycle later if cw_ready=1.
  - Peak rate is 1 byte per 2 cycles.
- Backpressure:
  - While cw_valid=1 and cw_ready=0, cw_data, cw_src and cw_last are stable.
  - No codeword is dropped or duplicated.
- A requester deasserting req_valid before its accept is legal and gets no grant.
- req_data is sampled only on the accept edge.
- rr_ptr advances only on accept.
- A sole active requester may be re-granted on consecutive bytes.
- Simultaneous events:
  - Same-edge cw_ready with a new load counts as consume plus load; cw_valid stays 1.
  - An IDLE accept and a HIGH load never coincide, since these are distinct states.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined: CW_W=8, and cw_data[7] = XOR of cw_data[6:0] (overall even parity, SECDED).
- Undefined: CW_W=7, with no parity bit.
- Timing, handshake and arbitration are identical in both builds.

Test Plan:
- Reset: assert reset_n=0 mid-HIGH with cw_valid=1 -> outputs go to 0 immediately (asynchronous); after release the first grant goes to requester 0.
- Single byte: req0 sends 0x5B, cw_ready=1 -> cw_data 0x33 (cw_last=0, cw_src=0), then 0x25 (cw_last=1); SECDED build gives 0x33 then 0xA5.
- Extremes: bytes 0x00 and then 0xFF -> codewords 0x00, 0x00, 0x7F, 0x7F; SECDED build gives 0x7F as 0xFF.
- Round-robin: all 4 requesters hold valid with bytes 0x10,0x21,0x32,0x43 -> grant order 0,1,2,3,0.
  - Each byte produces 2 consecutive codewords before the next req_ready.
  - One accept every 2 cycles.
- Backpressure: cw_ready=0 for 5 cycles after the low codeword -> cw_data holds 0x33, req_ready stays 0; after release the high codeword 0x25 appears and no codeword is lost or duplicated.
- Wrap: rr_ptr=3 with only req1 valid -> req1 is granted; rr_ptr becomes 2.
